// File: rtl/mem_wait.sv
// Memory-wait stage: holds one memory-stage result, drives its data-bus request until data_ok, then presents it to writeback.
// Optional build macro MEM_WAIT_MISALIGN_CHECK_EN: misaligned accesses skip the bus and are flagged in dataW.ctl.misalign.
`timescale 1ns/1ps

package mem_wait_pkg;

  typedef struct packed {
    logic [1:0] memsize;      // log2 of the access size in bytes
    logic       memread;
    logic       memwrite;
    logic       memunsigned;
    logic       regwrite;
`ifdef MEM_WAIT_MISALIGN_CHECK_EN
    logic       misalign;
`endif
  } ctl_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic [4:0]  dst;
    logic [63:0] aluout;
    logic [63:0] readdata;
    ctl_t        ctl;
  } memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

module mem_wait
  import mem_wait_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  memory_data_t dataM_in,
  input  dbus_req_t    dreq_in,
  output dbus_req_t    dreq,
  input  dbus_resp_t   dresp,
  output logic         out_valid,
  input  logic         out_ready,
  output memory_data_t dataW
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  state_e       state_q, state_d;
  dbus_req_t    dreq_q, dreq_d;
  memory_data_t data_q, data_d;
  logic         out_valid_q, out_valid_d;
  logic         accept;

  // Only data_ok matters here; the bus may raise addr_ok earlier or together with it.
  logic unused_addr_ok;
  assign unused_addr_ok = dresp.addr_ok;

  // Shift the addressed bytes to the bottom, then truncate and extend by shifting the access
  // width up to the MSB and back down (logical or arithmetic).
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] word,
                                                    input logic [2:0]        off,
                                                    input logic [1:0]        size,
                                                    input logic              is_unsigned);
    logic [DATA_W-1:0]        raw;
    logic [DATA_W-1:0]        left;
    logic signed [DATA_W-1:0] sext;
    logic [6:0]               sh;
    raw  = word >> {off, 3'b000};
    sh   = 7'd64 - (7'd8 << size);
    left = raw << sh;
    sext = $signed(left) >>> sh;
    return is_unsigned ? (left >> sh) : sext;
  endfunction

`ifdef MEM_WAIT_MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

  logic misalign_in;
  assign misalign_in = (dataM_in.ctl.memread || dataM_in.ctl.memwrite) &&
                       misaligned(dataM_in.aluout[2:0], dataM_in.ctl.memsize);
`endif

  // A new instruction is taken when idle, or in HOLD in the same cycle the old one drains.
  assign in_ready = !reset && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    state_d = state_q;
    dreq_d  = dreq_q;
    data_d  = data_q;

    case (state_q)
      BUSY: begin
        if (dresp.data_ok) begin
          data_d.readdata = data_q.ctl.memread
                          ? extend_load(dresp.data, data_q.aluout[2:0],
                                        data_q.ctl.memsize, data_q.ctl.memunsigned)
                          : '0;
          dreq_d.valid    = 1'b0;
          state_d         = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      data_d  = dataM_in;
      dreq_d  = '0;
      state_d = HOLD;
`ifdef MEM_WAIT_MISALIGN_CHECK_EN
      data_d.ctl.misalign = misalign_in;
      if (misalign_in) data_d.readdata = '0;
      else
`endif
      if (dreq_in.valid) begin
        dreq_d  = dreq_in;
        state_d = BUSY;
      end
    end

    out_valid_d = (state_d == HOLD);
  end

  // NOTE: sequential state uses non-blocking assignments only; reset clears every register
  // including the held request and result, so nothing stale leaks out after a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dreq_q      <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dreq_q      <= dreq_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dreq      = dreq_q;
  assign dataW     = data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mem_wait.sv
// Self-checking bench for mem_wait: directed scenarios plus random loads/stores/ALU ops
// checked against a byte-level reference model of load extraction and handshake timing.
`timescale 1ns/1ps

module tb_mem_wait;
  import mem_wait_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  memory_data_t dataM_in;
  dbus_req_t    dreq_in;
  dbus_req_t    dreq;
  dbus_resp_t   dresp;
  logic         out_valid;
  logic         out_ready;
  memory_data_t dataW;

  int n_tests = 0;
  int n_fail  = 0;

  mem_wait #(.DATA_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataM_in  (dataM_in),
    .dreq_in   (dreq_in),
    .dreq      (dreq),
    .dresp     (dresp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataW     (dataW)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference load: pick bytes starting at the offset, zero or sign fill above the access width.
  function automatic logic [63:0] model_load(input logic [63:0] word, input int off,
                                             input int nbytes, input bit uns);
    logic [63:0] val = '0;
    for (int i = 0; i < 8; i++)
      if (i < nbytes) val[8*i +: 8] = 8'(word >> (8 * (off + i)));
    if (!uns && val[8*nbytes-1])
      for (int i = 0; i < 8; i++)
        if (i >= nbytes) val[8*i +: 8] = 8'hFF;
    return val;
  endfunction

  function automatic bit model_misaligned(input memory_data_t m);
    int n = 1 << m.ctl.memsize;
    return (m.ctl.memread || m.ctl.memwrite) && (int'(m.aluout[2:0]) % n != 0);
  endfunction

  function automatic memory_data_t model_out(input memory_data_t m, input logic [63:0] bus);
    memory_data_t e = m;
`ifdef MEM_WAIT_MISALIGN_CHECK_EN
    e.ctl.misalign = model_misaligned(m);
    if (e.ctl.misalign) begin
      e.readdata = '0;
      return e;
    end
`endif
    if (m.ctl.memread)
      e.readdata = model_load(bus, int'(m.aluout[2:0]), 1 << m.ctl.memsize, m.ctl.memunsigned);
    else if (m.ctl.memwrite)
      e.readdata = '0;
    return e;
  endfunction

  function automatic bit model_uses_bus(input memory_data_t m, input dbus_req_t r);
`ifdef MEM_WAIT_MISALIGN_CHECK_EN
    return r.valid && !model_misaligned(m);
`else
    return r.valid && (m.pc == m.pc);
`endif
  endfunction

  // kind: 0 = ALU op, 1 = load, 2 = store
  task automatic build(input int kind, input int size, input bit uns, input int off,
                       output memory_data_t m, output dbus_req_t r);
    int n = 1 << size;
    m               = '0;
    m.pc            = {32'h0, $urandom};
    m.raw_instr     = $urandom;
    m.dst           = 5'($urandom);
    m.aluout        = {$urandom, $urandom};
    m.aluout[2:0]   = 3'(off);
    m.readdata      = {$urandom, $urandom};
    m.ctl.memsize   = 2'(size);
    m.ctl.memunsigned = uns;
    m.ctl.memread   = (kind == 1);
    m.ctl.memwrite  = (kind == 2);
    m.ctl.regwrite  = (kind != 2);
    r = '0;
    if (kind != 0) begin
      r.valid = 1'b1;
      r.addr  = m.aluout;
      r.size  = 2'(size);
      if (kind == 2) begin
        r.strobe = 8'(((1 << n) - 1) << off);
        r.data   = {$urandom, $urandom};
      end
    end
  endtask

  task automatic release_hold(input string tag);
    out_ready = 1'b1;
    #1;
    check({tag, "_rel_in_ready"}, in_ready, 1'b1);
    tick();
    out_ready = 1'b0;
    #1;
    check({tag, "_rel_out_valid"}, out_valid, 1'b0);
  endtask

  // One instruction from accept to HOLD; busy_n = BUSY cycles before the data_ok cycle.
  task automatic do_txn(input string tag, input memory_data_t m, input dbus_req_t r,
                        input int busy_n, input logic [63:0] bus, input int hold_n, input bit rel);
    memory_data_t exp_w = model_out(m, bus);
    dbus_req_t    exp_r = r;
    bit           uses  = model_uses_bus(m, r);
    dataM_in = m;
    dreq_in  = r;
    in_valid = 1'b1;
    #1;
    check({tag, "_accept_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    dataM_in = '0;
    dreq_in  = '0;
    if (uses) begin
      for (int c = 0; c <= busy_n; c++) begin
        dresp.data    = (c == busy_n) ? bus : {$urandom, $urandom};
        dresp.data_ok = (c == busy_n);
        dresp.addr_ok = (c == busy_n) || (c == 0);
        #1;
        check({tag, "_busy_dreq"}, dreq, exp_r);
        check({tag, "_busy_out_valid"}, out_valid, 1'b0);
        check({tag, "_busy_in_ready"}, in_ready, 1'b0);
        tick();
      end
      dresp = '0;
    end
    for (int c = 0; c < hold_n; c++) begin
      #1;
      check({tag, "_hold_out_valid"}, out_valid, 1'b1);
      check({tag, "_hold_dataW"}, dataW, exp_w);
      check({tag, "_hold_dreq_valid"}, dreq.valid, 1'b0);
      check({tag, "_hold_in_ready"}, in_ready, 1'b0);
      tick();
    end
    if (rel) release_hold(tag);
  endtask

  initial begin
    memory_data_t m, m2;
    dbus_req_t    r, r2;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dataM_in  = '0;
    dreq_in   = '0;
    dresp     = '0;
    tick();
    in_valid = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_dreq", dreq, '0);
    check("reset_dataW", dataW, '0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1'b1);

    // lb, signed, byte 3, data_ok on the third BUSY cycle -> out_valid 4 cycles after accept
    build(1, 0, 0, 3, m, r);
    do_txn("lb", m, r, 2, 64'h0000_0000_80FF_0000, 1, 1'b0);
    check("lb_value", dataW.readdata, 64'hFFFF_FFFF_FFFF_FF80);
    release_hold("lb");

    // lhu at offset 6, data_ok in the first BUSY cycle
    build(1, 1, 1, 6, m, r);
    do_txn("lhu", m, r, 0, 64'hBEEF_0000_0000_0000, 1, 1'b0);
    check("lhu_value", dataW.readdata, 64'h0000_0000_0000_BEEF);
    release_hold("lhu");

    // ALU op held by writeback for 5 cycles
    build(0, 3, 0, 0, m, r);
    do_txn("alu_hold", m, r, 0, 64'h0, 5, 1'b1);

    // store: readdata forced to zero
    build(2, 2, 0, 4, m, r);
    do_txn("sw", m, r, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1);

    // back-to-back: a load drains while the next ALU op is accepted in the same cycle
    build(1, 2, 0, 0, m, r);
    do_txn("b2b_lw", m, r, 1, 64'h1234_5678_9ABC_DEF0, 1, 1'b0);
    build(0, 0, 0, 0, m2, r2);
    dataM_in  = m2;
    dreq_in   = r2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", in_ready, 1'b1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dataM_in  = '0;
    #1;
    check("b2b_out_valid", out_valid, 1'b1);
    check("b2b_dataW", dataW, model_out(m2, 64'h0));
    release_hold("b2b");

    // reset in the second BUSY cycle; data_ok arriving afterwards is ignored
    build(1, 3, 0, 0, m, r);
    dataM_in = m;
    dreq_in  = r;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dataM_in = '0;
    dreq_in  = '0;
    #1;
    check("rst_busy1_valid", dreq.valid, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    check("rst_busy2_in_ready", in_ready, 1'b0);
    tick();
    reset         = 1'b0;
    dresp.data_ok = 1'b1;
    dresp.addr_ok = 1'b1;
    dresp.data    = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_dreq", dreq, '0);
    check("rst_dataW", dataW, '0);
    check("rst_in_ready", in_ready, 1'b1);
    tick();
    dresp = '0;
    #1;
    check("rst_late_out_valid", out_valid, 1'b0);
    check("rst_late_dreq_valid", dreq.valid, 1'b0);
    check("rst_late_dataW", dataW, '0);

    // lw at offset 2: bypasses the bus under the misalign check, otherwise issued unchanged
    build(1, 2, 0, 2, m, r);
    do_txn("lw_misalign", m, r, 1, 64'h1122_3344_8899_AABB, 1, 1'b0);
`ifdef MEM_WAIT_MISALIGN_CHECK_EN
    check("misalign_flag", dataW.ctl.misalign, 1'b1);
`else
    check("misalign_value", dataW.readdata, 64'h0000_0000_3344_8899);
`endif
    release_hold("lw_misalign");

    // randomized aligned traffic
    for (int t = 0; t < 30; t++) begin
      int kind = $urandom_range(0, 2);
      int size = $urandom_range(0, 3);
      int off  = ($urandom_range(0, 7) >> size) << size;
      build(kind, size, 1'($urandom), off, m, r);
      do_txn($sformatf("rnd%0d", t), m, r, $urandom_range(0, 3), {$urandom, $urandom},
             $urandom_range(1, 3), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wait.md
MEM_WAIT -- requirements
Module: mem_wait

Interface
REQ-001 SHALL have parameter: DATA_W, 64, data bus and writeback data width; only 64 is supported.
REQ-002 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  in  1  memory-stage result (dataM_in, dreq_in) is valid this cycle.
REQ-005 SHALL have port: in_ready  out  1  block accepts the input this cycle.
REQ-006 SHALL have port: dataM_in  in  memory_data_t  pc, raw_instr, dst, aluout, ctl (memsize, memread, memwrite, memunsigned, regwrite).
REQ-007 SHALL have port: dreq_in  in  dbus_req_t  combinational bus request from the memory stage.
REQ-008 SHALL have port: dreq  out  dbus_req_t  registered bus request to the data bus.
REQ-009 SHALL have port: dresp  in  dbus_resp_t  bus response (addr_ok, data_ok, data).
REQ-010 SHALL have port: out_valid  out  1  dataW holds a completed result.
REQ-011 SHALL have port: out_ready  in  1  writeback stage consumes dataW this cycle.
REQ-012 SHALL have port: dataW  out  memory_data_t  completed result; readdata holds the extended load value.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, HOLD.
REQ-014 IDLE: in_ready=1; a handshake (in_valid && in_ready) with dreq_in.valid=1 latches dataM_in and dreq_in, then moves to BUSY.
REQ-015 IDLE: a handshake with dreq_in.valid=0 latches dataM_in with readdata unchanged, then moves to HOLD with no bus activity.
REQ-016 BUSY: dreq SHALL equal the latched request with valid=1, stable until data_ok; in_ready=0.
REQ-017 BUSY: on dresp.data_ok=1 (addr_ok may rise in the same or an earlier cycle), SHALL capture the extended load data and move to HOLD.
REQ-018 dreq.valid SHALL drop in the cycle after data_ok and SHALL be 0 in IDLE and HOLD.
REQ-019 HOLD: out_valid=1 and dataW stable; on out_ready=1, if in_valid=1 the next request SHALL be accepted the same cycle (in_ready=out_ready); otherwise SHALL return to IDLE.
REQ-020 Load extraction: off=aluout[2:0]; raw=dresp.data >> (off*8); truncate to memsize (1/2/4/8 bytes); zero-extend if ctl.memunsigned, else sign-extend to 64 bits.
REQ-021 Stores SHALL pass dresp.data unused; dataW.readdata=0 for stores.
REQ-022 Minimum latency SHALL be 2 cycles from accept to out_valid for a bus access (data_ok in the first BUSY cycle) and 1 cycle for a non-memory instruction.
REQ-023 out_valid SHALL NOT depend combinationally on out_ready; in_ready MAY depend on out_ready in HOLD only.

Reset
REQ-024 reset=1 SHALL force IDLE, out_valid=0, dreq='0, dataW='0 on the next edge, overriding any other event.
REQ-025 Reset during BUSY SHALL abandon the transaction; a later data_ok for it SHALL be ignored while in IDLE.
REQ-026 in_ready SHALL be 0 during the reset cycle.

Configuration
REQ-027 Macro MEM_WAIT_MISALIGN_CHECK_EN: when defined, an access with aluout not aligned to memsize SHALL issue no bus request, go directly to HOLD, and set dataW.ctl.misalign=1 (a field present only under the macro).
REQ-028 Without the macro, misaligned accesses SHALL be issued to the bus unchanged and no misalign field SHALL exist.

Verification
REQ-029 lb at aluout=0x..03, memunsigned=0, data_ok after 3 cycles, dresp.data=0x0000_0000_80FF_0000 -> readdata=0xFFFF_FFFF_FFFF_FF80, out_valid 4 cycles after accept.
REQ-030 lhu at aluout=0x..06, data_ok in the first BUSY cycle, dresp.data=0xBEEF_0000_0000_0000 -> readdata=0x0000_0000_0000_BEEF, dreq stable until data_ok.
REQ-031 ALU op (no memread/memwrite), out_ready=0 for 5 cycles -> dreq.valid never 1, dataW held for 5 cycles, in_ready=0 until released.
REQ-032 Back-to-back: out_ready=1 and in_valid=1 in HOLD -> the next instruction is accepted in the same cycle, with no bubble.
REQ-033 Reset asserted in the second BUSY cycle, data_ok arriving the next cycle -> IDLE, out_valid=0, dreq.valid=0, response ignored.
REQ-034 With MEM_WAIT_MISALIGN_CHECK_EN: lw at aluout=0x..02 -> no dreq.valid, out_valid next cycle, misalign=1.
